// File: rtl/down_timer.sv
// Loadable down-counter/timer with one-shot or auto-reload operation and a registered done pulse.
// Optional tick prescaler is compiled in when DOWN_TIMER_PRESCALE_EN is defined.
`timescale 1ns/1ps

module down_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_reload, w_reload_nxt;
  logic             r_done, w_done_nxt;
  logic             w_tick;

  if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
    $error("down_timer: PRESCALE must be in 2..256");
  end

`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int unsigned PW = $clog2(PRESCALE);

  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          w_presc_term;

  assign w_presc_term = (r_presc == PW'(PRESCALE - 1));
  assign w_tick       = (r_state == ST_RUN) && enable && w_presc_term;

  always_comb begin
    w_presc_nxt = r_presc;
    if (load) begin
      w_presc_nxt = '0;
    end else if (r_state == ST_RUN && enable) begin
      w_presc_nxt = w_presc_term ? '0 : r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_presc <= '0;
    else          r_presc <= w_presc_nxt;
  end
`else
  assign w_tick = (r_state == ST_RUN) && enable;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    if (load) begin
      w_count_nxt  = load_value;
      w_reload_nxt = load_value;
      w_state_nxt  = (load_value != '0) ? ST_RUN : ST_IDLE;
    end else if (w_tick) begin
      // Terminal test uses <= 1 so the count can never wrap below zero.
      if (r_count <= WIDTH'(1)) begin
        w_done_nxt = 1'b1;
        if (mode) begin
          w_count_nxt = r_reload;
        end else begin
          w_count_nxt = '0;
          w_state_nxt = ST_IDLE;
        end
      end else begin
        w_count_nxt = r_count - WIDTH'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign count = r_count;
  assign busy  = (r_state == ST_RUN);
  assign done  = r_done;

endmodule
